spi_shift_engine: RTL and testbench

SPI master shift engine that drains the TX single-entry FIFO and fills the RX single-entry FIFO. Each frame pulls one word from the TX FIFO, shifts it out MSB-first in SPI mode 0 (CPOL=0, CPHA=0) under a framing slave-select, and pushes the simultaneously received word into the RX FIFO. It sits between the AXI-side FIFOs and the SPI pins.

---
 rtl/spi_shift_engine_pkg.sv | 30 +++
 rtl/spi_tick_gen.sv | 48 ++++
 rtl/spi_shift_engine.sv | 194 +++++++++++++++++++
 tb/tb_spi_shift_engine.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_shift_engine_pkg.sv
// -----------------------------------------------------------------------------
// spi_shift_engine_pkg
// Shared definitions for the SPI master shift engine:
//   - spi_state_e : frame sequencer state encoding
//   - clog2_min1  : ceiling log2 clamped to a minimum of 1 bit, used to size
//                   the half-period and bit counters from the parameters
// -----------------------------------------------------------------------------
package spi_shift_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TRAIL = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

    // Number of bits needed to hold values 0..value-1, never less than 1.
    function automatic int clog2_min1(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// -----------------------------------------------------------------------------
// spi_tick_gen
// Half-period tick generator. Counts g_clk_div clk_i cycles and raises tick_o
// in the last cycle of each period. clr_i restarts the count from zero on the
// next cycle so that every sequencer state begins a fresh period.
//
// Ports:
//   clk_i   in   system clock
//   rst_i   in   asynchronous active-low reset
//   clr_i   in   synchronous restart of the period counter
//   tick_o  out  high in the last cycle of each g_clk_div-cycle period
// -----------------------------------------------------------------------------
module spi_tick_gen
    import spi_shift_engine_pkg::*;
#(
    parameter int g_clk_div = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int            CW   = clog2_min1(g_clk_div);
    localparam logic [CW-1:0] LAST = CW'(g_clk_div - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    // Counter never runs past LAST: it returns to zero on the terminal count.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// -----------------------------------------------------------------------------
// spi_shift_engine
// SPI master (mode 0, MSB first) that pulls one word per frame from a TX
// single-entry FIFO, shifts it out on MOSI while sampling MISO, and pushes the
// received word into an RX single-entry FIFO.
//
// Frame: IDLE(1) -> LEAD(D) -> SHIFT(2W*D) -> TRAIL(D) -> GAP(D) -> IDLE
//
// Ports:
//   clk_i       in   system clock
//   rst_i       in   asynchronous active-low reset
//   tx_data_i   in   TX FIFO head word, valid while tx_empty_i=0
//   tx_empty_i  in   TX FIFO empty flag
//   tx_pull_o   out  one-cycle pull strobe to the TX FIFO
//   rx_data_o   out  last received word (held between frames)
//   rx_full_i   in   RX FIFO full flag
//   rx_push_o   out  one-cycle push strobe to the RX FIFO
//   sclk_o      out  SPI clock (registered, idle low)
//   mosi_o      out  SPI data out (registered)
//   miso_i      in   SPI data in
//   ss_n_o      out  active-low slave select (registered)
//   busy_o      out  high whenever a frame is in progress
// -----------------------------------------------------------------------------
module spi_shift_engine
    import spi_shift_engine_pkg::*;
#(
    parameter int g_width   = 32,
    parameter int g_clk_div = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [g_width-1:0] tx_data_i,
    input  logic               tx_empty_i,
    output logic               tx_pull_o,
    output logic [g_width-1:0] rx_data_o,
    input  logic               rx_full_i,
    output logic               rx_push_o,
    output logic               sclk_o,
    output logic               mosi_o,
    input  logic               miso_i,
    output logic               ss_n_o,
    output logic               busy_o
);

    // Half-period index within SHIFT runs 0..2W-1.
    localparam int            BW           = clog2_min1(2 * g_width + 1);
    localparam logic [BW-1:0] HP_LAST      = BW'(2 * g_width - 1);
    localparam logic [BW-1:0] HP_LAST_FALL = BW'(2 * g_width - 2);

    spi_state_e         state_q,   state_d;
    logic [BW-1:0]      hp_q,      hp_d;
    logic [g_width-1:0] tx_sr_q,   tx_sr_d;
    logic [g_width-1:0] rx_sr_q,   rx_sr_d;
    logic [g_width-1:0] rx_data_q, rx_data_d;
    logic               sclk_q,    sclk_d;
    logic               mosi_q,    mosi_d;
    logic               ss_n_q,    ss_n_d;
    logic               rx_push_q, rx_push_d;
    logic               ready_q;
    logic               tick;
    logic               tick_clr;
    logic               start;

    // ready_q keeps the pull strobe quiet in the first cycle after reset so a
    // word is never consumed while the frame registers are still held clear.
    assign start     = (state_q == ST_IDLE) && ready_q && !tx_empty_i && !rx_full_i;
    assign tx_pull_o = start;
    assign rx_data_o = rx_data_q;
    assign rx_push_o = rx_push_q;
    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;
    assign ss_n_o    = ss_n_q;
    assign busy_o    = (state_q != ST_IDLE);

    // Every state starts a fresh half-period; IDLE keeps the counter parked.
    assign tick_clr = (state_q == ST_IDLE) || (state_d != state_q);

    spi_tick_gen #(
        .g_clk_div (g_clk_div)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (tick_clr),
        .tick_o (tick)
    );

    always_comb begin
        state_d   = state_q;
        hp_d      = hp_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ss_n_d    = ss_n_q;
        rx_push_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ss_n_d = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                if (start) begin
                    tx_sr_d = tx_data_i;
                    hp_d    = '0;
                    mosi_d  = tx_data_i[g_width-1];
                    ss_n_d  = 1'b0;
                    state_d = ST_LEAD;
                end
            end

            ST_LEAD: begin
                // First rising SCLK edge: sample the first MISO bit.
                if (tick) begin
                    sclk_d  = 1'b1;
                    rx_sr_d = {rx_sr_q[g_width-2:0], miso_i};
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (tick) begin
                    if (hp_q == HP_LAST) begin
                        state_d = ST_TRAIL;
                    end else begin
                        hp_d = hp_q + 1'b1;
                        if (hp_q[0]) begin
                            // End of a low half-period: rise and sample.
                            sclk_d  = 1'b1;
                            rx_sr_d = {rx_sr_q[g_width-2:0], miso_i};
                        end else begin
                            // End of a high half-period: fall. MOSI advances
                            // except on the final fall, where bit 0 is held
                            // through TRAIL. The register rotates so its
                            // top bit always mirrors the bit on MOSI.
                            sclk_d = 1'b0;
                            if (hp_q != HP_LAST_FALL) begin
                                mosi_d  = tx_sr_q[g_width-2];
                                tx_sr_d = {tx_sr_q[g_width-2:0], tx_sr_q[g_width-1]};
                            end
                        end
                    end
                end
            end

            ST_TRAIL: begin
                if (tick) begin
                    ss_n_d    = 1'b1;
                    mosi_d    = 1'b0;
                    rx_push_d = 1'b1;
                    rx_data_d = rx_sr_q;
                    state_d   = ST_GAP;
                end
            end

            ST_GAP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            hp_q      <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ss_n_q    <= 1'b1;
            rx_push_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hp_q      <= hp_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ss_n_q    <= ss_n_d;
            rx_push_q <= rx_push_d;
            ready_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// -----------------------------------------------------------------------------
// tb_spi_shift_engine
// Directed bench for spi_shift_engine. Instance 0 runs W=8, D=2; instance 1
// runs W=8, D=1. Inputs change 1 ns after the rising edge, outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_spi_shift_engine;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] tx_data_a  [2];
    logic         tx_empty_a [2];
    logic         pull_a     [2];
    logic [W-1:0] rx_data_a  [2];
    logic         rx_full_a  [2];
    logic         push_a     [2];
    logic         sclk_a     [2];
    logic         mosi_a     [2];
    logic         miso_a     [2];
    logic         ss_n_a     [2];
    logic         busy_a     [2];
    logic         loop_a     [2];
    logic         miso_val_a [2];

    int checks = 0;
    int errors = 0;

    assign miso_a[0] = loop_a[0] ? mosi_a[0] : miso_val_a[0];
    assign miso_a[1] = loop_a[1] ? mosi_a[1] : miso_val_a[1];

    spi_shift_engine #(.g_width(W), .g_clk_div(2)) u_dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .tx_data_i  (tx_data_a[0]),
        .tx_empty_i (tx_empty_a[0]),
        .tx_pull_o  (pull_a[0]),
        .rx_data_o  (rx_data_a[0]),
        .rx_full_i  (rx_full_a[0]),
        .rx_push_o  (push_a[0]),
        .sclk_o     (sclk_a[0]),
        .mosi_o     (mosi_a[0]),
        .miso_i     (miso_a[0]),
        .ss_n_o     (ss_n_a[0]),
        .busy_o     (busy_a[0])
    );

    spi_shift_engine #(.g_width(W), .g_clk_div(1)) u_dut_d1 (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .tx_data_i  (tx_data_a[1]),
        .tx_empty_i (tx_empty_a[1]),
        .tx_pull_o  (pull_a[1]),
        .rx_data_o  (rx_data_a[1]),
        .rx_full_i  (rx_full_a[1]),
        .rx_push_o  (push_a[1]),
        .sclk_o     (sclk_a[1]),
        .mosi_o     (mosi_a[1]),
        .miso_i     (miso_a[1]),
        .ss_n_o     (ss_n_a[1]),
        .busy_o     (busy_a[1])
    );

    // Wait (bounded) until instance s is idle.
    task automatic wait_idle(input int s);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (busy_a[s] === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_idle[%0d] busy got %b required 0 within 100 cycles", s, busy_a[s]);
        end
    endtask

    // Run one frame on instance s and report what was observed.
    task automatic do_frame(input int s, input logic [7:0] data, input bit loop, input bit mv,
                            output logic [7:0] mosi_bits, output logic [7:0] rx_word,
                            output int ss_low, output int push_off, output int rise_per);
        int  t0, first_rise, n_rise;
        bit  prev_sclk, got_pull, got_push;
        @(posedge clk); #1;
        loop_a[s]     = loop;
        miso_val_a[s] = mv;
        tx_data_a[s]  = data;
        tx_empty_a[s] = 1'b0;
        prev_sclk = 1'b0; got_pull = 1'b0; got_push = 1'b0;
        ss_low = 0; push_off = -1; rise_per = -1; n_rise = 0;
        mosi_bits = 8'h00; rx_word = 8'h00; t0 = 0; first_rise = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!got_pull && pull_a[s] === 1'b1) begin
                got_pull = 1'b1;
                t0 = k;
            end else if (got_pull) begin
                if (ss_n_a[s] === 1'b0) ss_low++;
                if (sclk_a[s] === 1'b1 && !prev_sclk) begin
                    mosi_bits = {mosi_bits[6:0], mosi_a[s]};
                    if (n_rise == 0) first_rise = k;
                    else if (n_rise == 1) rise_per = k - first_rise;
                    n_rise++;
                end
                if (push_a[s] === 1'b1) begin
                    push_off = k - t0;
                    rx_word  = rx_data_a[s];
                    got_push = 1'b1;
                end
            end
            prev_sclk = (sclk_a[s] === 1'b1);
            @(posedge clk); #1;
            if (got_pull) tx_empty_a[s] = 1'b1;
            if (got_push) break;
        end
    endtask

    // Two queued words; report pull spacing and received words.
    task automatic do_two(input int s, input logic [7:0] d0, input logic [7:0] d1,
                          output int gap, output logic [7:0] r0, output logic [7:0] r1);
        int sent, npush, p0;
        bit popped;
        @(posedge clk); #1;
        loop_a[s] = 1'b1; tx_data_a[s] = d0; tx_empty_a[s] = 1'b0;
        sent = 0; npush = 0; p0 = -1; gap = -1; r0 = 8'h00; r1 = 8'h00;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            popped = 1'b0;
            if (pull_a[s] === 1'b1) begin
                if (sent == 0) p0 = k;
                else if (sent == 1) gap = k - p0;
                sent++;
                popped = 1'b1;
            end
            if (push_a[s] === 1'b1) begin
                if (npush == 0) r0 = rx_data_a[s];
                else r1 = rx_data_a[s];
                npush++;
            end
            @(posedge clk); #1;
            if (popped) begin
                if (sent == 1) tx_data_a[s] = d1;
                else tx_empty_a[s] = 1'b1;
            end
            if (npush >= 2) break;
        end
    endtask

    task automatic test_reset;
        for (int s = 0; s < 2; s++) begin
            tx_data_a[s] = '0; tx_empty_a[s] = 1'b1; rx_full_a[s] = 1'b0;
            loop_a[s] = 1'b0; miso_val_a[s] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({ss_n_a[s], sclk_a[s], mosi_a[s], pull_a[s], push_a[s], busy_a[s]} !== 6'b100000) begin
                errors++;
                $display("FAIL reset_ctrl[%0d] got ss,sclk,mosi,pull,push,busy=%b%b%b%b%b%b required 100000",
                         s, ss_n_a[s], sclk_a[s], mosi_a[s], pull_a[s], push_a[s], busy_a[s]);
            end
            checks++;
            if (rx_data_a[s] !== 8'h00) begin
                errors++;
                $display("FAIL reset_rx_data[%0d] got %h required 00", s, rx_data_a[s]);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_loopback;
        logic [7:0] mb, rw;
        int ssl, po, rp;
        wait_idle(0);
        do_frame(0, 8'hA5, 1'b1, 1'b0, mb, rw, ssl, po, rp);
        checks++;
        if (mb !== 8'hA5) begin errors++; $display("FAIL loop_mosi_bits got %h required a5", mb); end
        checks++;
        if (ssl != 36) begin errors++; $display("FAIL loop_ss_low got %0d required 36", ssl); end
        checks++;
        if (po != 37) begin errors++; $display("FAIL loop_push_latency got %0d required 37", po); end
        checks++;
        if (rw !== 8'hA5) begin errors++; $display("FAIL loop_rx_data got %h required a5", rw); end
        checks++;
        if (rp != 4) begin errors++; $display("FAIL loop_sclk_period got %0d required 4", rp); end
    endtask

    task automatic test_miso_const;
        logic [7:0] mb, rw;
        int ssl, po, rp;
        wait_idle(0);
        do_frame(0, 8'h00, 1'b0, 1'b1, mb, rw, ssl, po, rp);
        checks++;
        if (rw !== 8'hFF) begin errors++; $display("FAIL miso_one_rx got %h required ff", rw); end
        checks++;
        if (mb !== 8'h00) begin errors++; $display("FAIL miso_one_mosi got %h required 00", mb); end
        wait_idle(0);
        do_frame(0, 8'h3C, 1'b0, 1'b0, mb, rw, ssl, po, rp);
        checks++;
        if (rw !== 8'h00) begin errors++; $display("FAIL miso_zero_rx got %h required 00", rw); end
        checks++;
        if (mb !== 8'h3C) begin errors++; $display("FAIL miso_zero_mosi got %h required 3c", mb); end
    endtask

    task automatic test_backpressure;
        bit got_push;
        wait_idle(0);
        @(posedge clk); #1;
        rx_full_a[0] = 1'b1; tx_data_a[0] = 8'h66; tx_empty_a[0] = 1'b0; loop_a[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if ({pull_a[0], ss_n_a[0], busy_a[0]} !== 3'b010) begin
                errors++;
                $display("FAIL hold_cycle%0d got pull,ss,busy=%b%b%b required 010",
                         k, pull_a[0], ss_n_a[0], busy_a[0]);
            end
        end
        @(posedge clk); #1;
        rx_full_a[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (pull_a[0] !== 1'b1) begin errors++; $display("FAIL release_pull got %b required 1", pull_a[0]); end
        @(posedge clk); #1;
        tx_empty_a[0] = 1'b1;
        got_push = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (push_a[0] === 1'b1) begin got_push = 1'b1; break; end
        end
        checks++;
        if (!got_push || rx_data_a[0] !== 8'h66) begin
            errors++;
            $display("FAIL release_frame got push=%b data=%h required push=1 data=66", got_push, rx_data_a[0]);
        end
    endtask

    task automatic test_back_to_back;
        int gap;
        logic [7:0] r0, r1;
        wait_idle(0);
        do_two(0, 8'h12, 8'h34, gap, r0, r1);
        checks++;
        if (gap != 39) begin errors++; $display("FAIL b2b_pull_gap got %0d required 39", gap); end
        checks++;
        if (r0 !== 8'h12) begin errors++; $display("FAIL b2b_rx0 got %h required 12", r0); end
        checks++;
        if (r1 !== 8'h34) begin errors++; $display("FAIL b2b_rx1 got %h required 34", r1); end
    endtask

    task automatic test_reset_mid;
        int n_rise, pushes;
        bit prev, hit, pulled;
        logic [7:0] mb, rw;
        int ssl, po, rp;
        wait_idle(0);
        @(posedge clk); #1;
        loop_a[0] = 1'b1; tx_data_a[0] = 8'h77; tx_empty_a[0] = 1'b0;
        n_rise = 0; pushes = 0; prev = 1'b0; hit = 1'b0; pulled = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (pull_a[0] === 1'b1) pulled = 1'b1;
            if (sclk_a[0] === 1'b1 && !prev) n_rise++;
            prev = (sclk_a[0] === 1'b1);
            if (push_a[0] === 1'b1) pushes++;
            @(posedge clk); #1;
            if (pulled) tx_empty_a[0] = 1'b1;
            if (n_rise == 4) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit || sclk_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_reach_high4 got rises=%0d sclk=%b required 4 and 1", n_rise, sclk_a[0]);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({ss_n_a[0], sclk_a[0], busy_a[0], push_a[0]} !== 4'b1000) begin
            errors++;
            $display("FAIL mid_reset_state got ss,sclk,busy,push=%b%b%b%b required 1000",
                     ss_n_a[0], sclk_a[0], busy_a[0], push_a[0]);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (push_a[0] === 1'b1) pushes++;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (push_a[0] === 1'b1) pushes++;
        end
        checks++;
        if (pushes != 0) begin errors++; $display("FAIL mid_no_push got %0d pushes required 0", pushes); end
        do_frame(0, 8'hC3, 1'b1, 1'b0, mb, rw, ssl, po, rp);
        checks++;
        if (rw !== 8'hC3 || po != 37) begin
            errors++;
            $display("FAIL mid_next_frame got data=%h latency=%0d required c3 and 37", rw, po);
        end
    endtask

    task automatic test_d1;
        logic [7:0] mb, rw, r0, r1;
        int ssl, po, rp, gap;
        wait_idle(1);
        do_frame(1, 8'h5A, 1'b1, 1'b0, mb, rw, ssl, po, rp);
        checks++;
        if (rw !== 8'h5A) begin errors++; $display("FAIL d1_rx got %h required 5a", rw); end
        checks++;
        if (rp != 2) begin errors++; $display("FAIL d1_sclk_period got %0d required 2", rp); end
        checks++;
        if (ssl != 18 || po != 19) begin
            errors++;
            $display("FAIL d1_timing got ss_low=%0d latency=%0d required 18 and 19", ssl, po);
        end
        wait_idle(1);
        do_two(1, 8'h5A, 8'hC3, gap, r0, r1);
        checks++;
        if (gap != 20) begin errors++; $display("FAIL d1_frame_period got %0d required 20", gap); end
        checks++;
        if (r0 !== 8'h5A || r1 !== 8'hC3) begin
            errors++;
            $display("FAIL d1_b2b_rx got %h,%h required 5a,c3", r0, r1);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_miso_const();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_d1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
